// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and state encodings for the PS/2 keyboard receive path.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] BKSP_CODE  = 8'h66;
  localparam logic [7:0] ENTER_CODE = 8'h5A;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic       {NORMAL, BREAK}            dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, 11-bit frame FSM and timeout.
// byte_done/frame_error are registered pulses, 1 cycle after the synchronised stop-bit edge.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_error
);
  import ps2_key_decoder_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          fall, bit_in, timeout;
  rx_state_t     state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic          byte_done_nx, frame_error_nx;

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rx_byte = shreg;

  // Synchroniser flops reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      clk_prev    <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk};
      data_sync   <= {data_sync[0], ps2_data};
      clk_prev    <= clk_sync[1];
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      par         <= par_nx;
      to_cnt      <= to_cnt_nx;
      byte_done   <= byte_done_nx;
      frame_error <= frame_error_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    bit_cnt_nx     = bit_cnt;
    shreg_nx       = shreg;
    par_nx         = par;
    byte_done_nx   = 1'b0;
    frame_error_nx = 1'b0;
    to_cnt_nx      = (state == IDLE || fall) ? '0 : to_cnt + 1'b1;

    if (timeout) begin
      state_nx       = IDLE;
      frame_error_nx = 1'b1;
      to_cnt_nx      = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end
        end
        DATA: begin
          shreg_nx   = {bit_in, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = bit_in;
          state_nx = STOP;
        end
        STOP: begin
          if (bit_in && (^{shreg, par}))
            byte_done_nx = 1'b1;
          else
            frame_error_nx = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 make/break decoder: turns received scan-code bytes into held-key level outputs.
// Outputs update 1 cycle after byte_done; qualifiers clear 1 cycle after key_press falls.
module ps2_key_decoder #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] BKSP_CODE      = ps2_key_decoder_pkg::BKSP_CODE,
  parameter logic [7:0] ENTER_CODE     = ps2_key_decoder_pkg::ENTER_CODE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       key_press,
  output logic       backspace,
  output logic       enter,
  output logic       frame_error
);
  import ps2_key_decoder_pkg::*;

  logic [7:0] rx_byte;
  logic       byte_done;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_byte     (rx_byte),
    .byte_done   (byte_done),
    .frame_error (frame_error)
  );

  dec_state_t dec_state, dec_state_nx;
  logic [7:0] held, held_nx, scan_nx;
  logic       cv_nx, kp_nx, bksp_nx, ent_nx;
  logic       clr_q, clr_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_state  <= NORMAL;
      held       <= 8'h00;
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      key_press  <= 1'b0;
      backspace  <= 1'b0;
      enter      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      dec_state  <= dec_state_nx;
      held       <= held_nx;
      scan_code  <= scan_nx;
      code_valid <= cv_nx;
      key_press  <= kp_nx;
      backspace  <= bksp_nx;
      enter      <= ent_nx;
      clr_q      <= clr_nx;
    end
  end

  always_comb begin
    dec_state_nx = dec_state;
    held_nx      = held;
    scan_nx      = scan_code;
    cv_nx        = 1'b0;
    kp_nx        = key_press;
    bksp_nx      = backspace;
    ent_nx       = enter;
    clr_nx       = 1'b0;

    // Qualifiers outlive key_press by one cycle so a negedge sampler sees them stable.
    if (clr_q) begin
      bksp_nx = 1'b0;
      ent_nx  = 1'b0;
    end

    if (byte_done) begin
      case (dec_state)
        NORMAL: begin
          if (rx_byte == PS2_BREAK) begin
            dec_state_nx = BREAK;
          end else if (rx_byte != PS2_EXT && !(key_press && rx_byte == held)) begin
            held_nx = rx_byte;
            scan_nx = rx_byte;
            cv_nx   = 1'b1;
            kp_nx   = 1'b1;
            bksp_nx = (rx_byte == BKSP_CODE);
            ent_nx  = (rx_byte == ENTER_CODE);
          end
        end
        BREAK: begin
          dec_state_nx = NORMAL;
          if (key_press && rx_byte == held) begin
            kp_nx  = 1'b0;
            clr_nx = 1'b1;
          end
        end
        default: dec_state_nx = NORMAL;
      endcase
    end
  end

endmodule
